// File: rtl/shift_pkg.sv
// Shared types for the sequential shifter.
//   shift_mode_t  : operation select, encoded to match the 2-bit mode port
//   shift_state_t : control FSM states
package shift_pkg;

    typedef enum logic [1:0] {
        LSR = 2'b00,
        LSL = 2'b01,
        ASR = 2'b10,
        ROR = 2'b11
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } shift_state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift step.
//   value      : current working value
//   mode       : operation to apply
//   next_value : value after one 1-bit step
//   out_bit    : bit shifted out by this step
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  shift_mode_t      mode,
    output logic [WIDTH-1:0] next_value,
    output logic             out_bit
);

    always_comb begin
        next_value = value;
        out_bit    = 1'b0;
        case (mode)
            LSR: begin
                next_value = {1'b0, value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            LSL: begin
                next_value = {value[WIDTH-2:0], 1'b0};
                out_bit    = value[WIDTH-1];
            end
            ASR: begin
                next_value = {value[WIDTH-1], value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            ROR: begin
                next_value = {value[0], value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            default: begin
                next_value = value;
                out_bit    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Sequential multi-cycle shifter: one bit per cycle, shamt cycles per op.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : launch an operation (only honoured in IDLE)
//   mode       : 00 LSR, 01 LSL, 10 ASR, 11 ROR
//   a, shamt   : operand and shift amount, captured at start
//   busy       : operation in progress (SHIFT or DONE)
//   done       : one-cycle pulse, result and flags just updated
//   result     : registered result, held until the next completion
//   zero_flag, carry_flag, neg_flag : status of result / last bit out
module seq_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               zero_flag,
    output logic               carry_flag,
    output logic               neg_flag
);

    shift_state_t       state_q, state_d;
    shift_mode_t        mode_q, mode_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               neg_q, neg_d;

    logic [WIDTH-1:0]   step_val;
    logic               step_out;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .value      (work_q),
        .mode       (mode_q),
        .next_value (step_val),
        .out_bit    (step_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= LSR;
            work_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            carry_q  <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            neg_q    <= neg_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d = a;
                    mode_d = shift_mode_t'(mode);
                    cnt_d  = shamt;
                    if (shamt != '0) begin
                        state_d = SHIFT;
                    end else begin
                        // Zero-length shift completes straight away.
                        state_d  = DONE;
                        result_d = a;
                        carry_d  = 1'b0;
                    end
                end
            end
            SHIFT: begin
                work_d = step_val;
                cnt_d  = cnt_q - 1'b1;
                // Leave on the step that takes the counter to zero, so
                // the counter never decrements past zero.
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d  = DONE;
                    result_d = step_val;
                    carry_d  = step_out;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Flags track result_d, so they only move when result does.
        zero_d = (result_d == '0);
        neg_d  = result_d[WIDTH-1];
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign result     = result_q;
    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;
    assign neg_flag   = neg_q;

endmodule

// File: tb/tb_seq_shifter.sv
module tb_seq_shifter;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic [7:0] a;
    logic [2:0] shamt;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       zero_flag;
    logic       carry_flag;
    logic       neg_flag;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_res;
    logic       exp_carry;

    seq_shifter #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .a          (a),
        .shamt      (shamt),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .neg_flag   (neg_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole shift by s computed in one go; returns {carry, result}.
    function automatic logic [8:0] ref_op(input logic [1:0] m, input logic [7:0] x, input int s);
        logic [7:0] r;
        logic       c;
        if (s == 0) return {1'b0, x};
        case (m)
            2'd0: begin r = x >> s; c = x[3'(s - 1)]; end
            2'd1: begin r = x << s; c = x[3'(8 - s)]; end
            2'd2: begin r = 8'($signed(x) >>> s); c = x[3'(s - 1)]; end
            default: begin r = (x >> s) | (x << (8 - s)); c = x[3'(s - 1)]; end
        endcase
        return {c, r};
    endfunction

    // Called just after a falling edge. Launches one op, optionally
    // disturbing start/a/mode/shamt while busy, and checks completion.
    task automatic run_op(input logic [1:0] m, input logic [7:0] x, input int s, input bit perturb);
        logic [8:0] e;
        int         cyc;
        bit         seen;
        e     = ref_op(m, x, s);
        start = 1'b1;
        mode  = m;
        a     = x;
        shamt = 3'(s);
        @(posedge clk);
        #1;
        start = perturb;
        if (perturb) begin
            a     = ~x;
            mode  = 2'($urandom);
            shamt = 3'($urandom);
        end
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                seen = 1'b1;
            end else begin
                chk("held_result", 32'(result), 32'(exp_res));
                chk("busy_shift", 32'(busy), 32'd1);
                if (perturb) begin
                    a    = 8'($urandom);
                    mode = 2'($urandom);
                end
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(cyc), 32'(s + 1));
        chk("busy_done", 32'(busy), 32'd1);
        chk("result", 32'(result), 32'(e[7:0]));
        chk("carry", 32'(carry_flag), 32'(e[8]));
        chk("zero", 32'(zero_flag), 32'(e[7:0] == 8'h00));
        chk("neg", 32'(neg_flag), 32'(e[7]));
        start = 1'b0;
        @(negedge clk);
        chk("done_pulse_one", 32'(done), 32'd0);
        chk("idle_after", 32'(busy), 32'd0);
        exp_res   = e[7:0];
        exp_carry = e[8];
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 2'd0;
        a     = 8'h00;
        shamt = 3'd0;
        exp_res   = 8'h00;
        exp_carry = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_zero", 32'(zero_flag), 32'd1);
        chk("rst_carry", 32'(carry_flag), 32'd0);
        chk("rst_neg", 32'(neg_flag), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed vectors with literal expectations.
        run_op(2'd0, 8'hB5, 1, 1'b0);
        chk("lsr_b5_res", 32'(result), 32'h5A);
        chk("lsr_b5_c", 32'(carry_flag), 32'd1);
        run_op(2'd1, 8'h81, 3, 1'b0);
        chk("lsl_81_res", 32'(result), 32'h08);
        chk("lsl_81_c", 32'(carry_flag), 32'd0);
        run_op(2'd2, 8'h80, 7, 1'b0);
        chk("asr_80_res", 32'(result), 32'hFF);
        chk("asr_80_n", 32'(neg_flag), 32'd1);
        run_op(2'd0, 8'h01, 1, 1'b0);
        chk("lsr_01_z", 32'(zero_flag), 32'd1);
        chk("lsr_01_c", 32'(carry_flag), 32'd1);
        run_op(2'd3, 8'h01, 1, 1'b0);
        chk("ror_01_res", 32'(result), 32'h80);
        chk("ror_01_n", 32'(neg_flag), 32'd1);
        run_op(2'd1, 8'h3C, 0, 1'b0);
        chk("sh0_res", 32'(result), 32'h3C);
        chk("sh0_c", 32'(carry_flag), 32'd0);

        // Disturbed operation: start re-pulsed and operands changed while busy.
        run_op(2'd1, 8'h81, 3, 1'b1);
        chk("perturb_res", 32'(result), 32'h08);

        // Idle with start low: nothing moves.
        for (int i = 0; i < 4; i++) begin
            a     = 8'($urandom);
            mode  = 2'($urandom);
            shamt = 3'($urandom);
            @(negedge clk);
            chk("idle_hold_res", 32'(result), 32'(exp_res));
            chk("idle_hold_c", 32'(carry_flag), 32'(exp_carry));
            chk("idle_busy", 32'(busy), 32'd0);
        end

        // Reset during the second SHIFT cycle of LSL 0xFF by 5.
        start = 1'b1;
        mode  = 2'd1;
        a     = 8'hFF;
        shamt = 3'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_result", 32'(result), 32'd0);
        chk("arst_zero", 32'(zero_flag), 32'd1);
        chk("arst_carry", 32'(carry_flag), 32'd0);
        chk("arst_neg", 32'(neg_flag), 32'd0);
        exp_res   = 8'h00;
        exp_carry = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("arst_no_done", 32'(done), 32'd0);
        end
        rst = 1'b0;
        run_op(2'd1, 8'hFF, 5, 1'b0);
        chk("post_rst_res", 32'(result), 32'hE0);

        // Randomized operations against the reference.
        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom), 8'($urandom), int'($urandom_range(0, 7)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand/result width in bits (legal range 2..32).
REQ-002 The block SHALL have derived parameter SHAMT_W, default $clog2(WIDTH), giving the shift-amount width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, all state on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request a new shift; sampled only in IDLE.
REQ-006 The block SHALL have port mode, input, 2 bits: operation select; 00 LSR, 01 LSL, 10 ASR, 11 ROR.
REQ-007 The block SHALL have port a, input, WIDTH bits: the operand.
REQ-008 The block SHALL have port shamt, input, SHAMT_W bits: shift amount, 0..WIDTH-1.
REQ-009 The block SHALL have port busy, output, 1 bit: high in SHIFT and DONE states.
REQ-010 The block SHALL have port done, output, 1 bit: single-cycle pulse marking that result and flags are updated.
REQ-011 The block SHALL have port result, output, WIDTH bits: registered shift result.
REQ-012 The block SHALL have port zero_flag, output, 1 bit: high when result is all zeros.
REQ-013 The block SHALL have port carry_flag, output, 1 bit: holds the last bit shifted out.
REQ-014 The block SHALL have port neg_flag, output, 1 bit: equal to result[WIDTH-1].

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-016 IDLE with start=1: capture a, mode and shamt into internal registers; go to SHIFT if shamt!=0, else go to DONE.
REQ-017 IDLE with start=0: stay in IDLE, internal registers and outputs unchanged.
REQ-018 SHIFT: each cycle perform one 1-bit step of the captured mode on the working register and decrement the counter; go to DONE on the step where the counter reaches 0.
REQ-019 LSR step: insert 0 at the MSB; the shifted-out bit is working[0].
REQ-020 LSL step: insert 0 at bit 0; the shifted-out bit is working[WIDTH-1].
REQ-021 ASR step: replicate working[WIDTH-1] into the MSB; the shifted-out bit is working[0].
REQ-022 ROR step: working[0] moves to the MSB; the shifted-out bit is working[0].
REQ-023 result, zero_flag, carry_flag and neg_flag SHALL update only on the transition into DONE, and SHALL be held until the next transition into DONE.
REQ-024 When shamt=0: result=a, carry_flag=0, and the other flags are derived from a.
REQ-025 DONE SHALL assert done for exactly one cycle and then return unconditionally to IDLE.
REQ-026 Latency: with start sampled in cycle 0, done SHALL be high in cycle shamt+1; the next start is accepted no earlier than cycle shamt+2.
REQ-027 start SHALL be ignored while busy=1, with no queuing and no effect on the operation in progress.
REQ-028 a, mode and shamt changing during SHIFT SHALL NOT affect the operation in progress.
REQ-029 Counter width SHALL be SHAMT_W; counter wrap SHALL NOT be possible.

Reset
REQ-030 rst=1 SHALL force, asynchronously: state=IDLE, busy=0, done=0, result=0, zero_flag=1, carry_flag=0, neg_flag=0; counter and working register cleared.
REQ-031 rst asserted mid-operation SHALL abort it: no done pulse, and previous results are lost.
REQ-032 The first start after rst deassertion SHALL be accepted on the first rising edge at which rst is low.

Structure
REQ-033 Package shift_pkg SHALL hold the shift_mode_t enum (LSR, LSL, ASR, ROR) and the shift_state_t enum (IDLE, SHIFT, DONE).
REQ-034 The single-step datapath SHALL be a combinational sub-module shift_step (inputs: value, mode; outputs: next value, out bit), instantiated once.
REQ-035 No other sub-modules SHALL be used; the FSM, counter and flag registers SHALL reside in seq_shifter.

Verification (WIDTH=8)
REQ-036 LSR, a=0xB5, shamt=1 -> done in cycle 2; result=0x5A, carry=1, zero=0, neg=0.
REQ-037 LSL, a=0x81, shamt=3 -> done in cycle 4; result=0x08, carry=0, neg=0.
REQ-038 ASR, a=0x80, shamt=7 -> done in cycle 8; result=0xFF, carry=0, neg=1; and LSR, a=0x01, shamt=1 -> result=0x00, zero=1, carry=1.
REQ-039 ROR, a=0x01, shamt=1 -> result=0x80, carry=1, neg=1; and shamt=0 with a=0x3C -> done in cycle 1, result=0x3C, carry=0.
REQ-040 start pulsed again while busy, with a changed mid-SHIFT -> result matches the original operands; exactly one done pulse.
REQ-041 rst asserted in the 2nd SHIFT cycle of LSL a=0xFF, shamt=5 -> outputs at reset values immediately, no done pulse; a new start then completes normally.
